// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial subtractor FSM states and a
// counter-width helper sized for bit-serial operators.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_sub_state_t;

    // Bits needed to count 0..width-1, never less than one.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one cell plus a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    serial_sub_state_t state_reg;
    serial_sub_state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             borrow_reg;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .x    (a_reg[0]),
        .y    (b_reg[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operands shift out LSB first, result bits enter at the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        diff_reg   <= '0;
                        cnt_reg    <= '0;
                        borrow_reg <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_reg      <= a_reg >> 1;
                    b_reg      <= b_reg >> 1;
                    diff_reg   <= {cell_d, diff_reg[WIDTH-1:1]};
                    borrow_reg <= cell_bout;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;

    // MSBs are lost from the shift registers, so keep copies from launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                a_msb_reg <= a[WIDTH-1];
                b_msb_reg <= b[WIDTH-1];
                ovf_reg   <= 1'b0;
            end else if (state_reg == SHIFT && cnt_reg == LAST_CNT) begin
                ovf_reg <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
            end
        end
    end

    assign ovf = ovf_reg;
`endif

    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 4;
    localparam int BOUND = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int assertions = 0;
    int failures   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from idle and check result, latency and busy width.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input string name);
        int cycles;
        int busy_cycles;
        int ia, ib, sd;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        exp_diff   = W'((int'(ta) - int'(tb_)) & ((1 << W) - 1));
        exp_borrow = (ta < tb_);
        start = 1'b1; a = ta; b = tb_;
        step();
        start = 1'b0;
        cycles = 0;
        busy_cycles = 0;
        while (!done && cycles < BOUND) begin
            if (busy) busy_cycles++;
            step();
            cycles++;
        end
        assertions++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles", name, BOUND);
            return;
        end
        assertions++;
        if (cycles !== W) begin
            failures++;
            $display("FAIL %s latency: done after %0d cycles, required %0d", name, cycles, W);
        end
        assertions++;
        if (busy_cycles + (busy ? 1 : 0) !== W + 1) begin
            failures++;
            $display("FAIL %s busy_width: got %0d, required %0d", name, busy_cycles + (busy ? 1 : 0), W + 1);
        end
        assertions++;
        if (diff !== exp_diff || borrow !== exp_borrow) begin
            failures++;
            $display("FAIL %s result: diff=%h borrow=%b, required diff=%h borrow=%b",
                     name, diff, borrow, exp_diff, exp_borrow);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        begin
            logic exp_ovf;
            ia = (ta[W-1]) ? int'(ta) - (1 << W) : int'(ta);
            ib = (tb_[W-1]) ? int'(tb_) - (1 << W) : int'(tb_);
            sd = ia - ib;
            exp_ovf = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
            assertions++;
            if (ovf !== exp_ovf) begin
                failures++;
                $display("FAIL %s ovf: got %b, required %b", name, ovf, exp_ovf);
            end
        end
`else
        ia = 0; ib = 0; sd = 0;
`endif
        step();
        assertions++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== exp_diff || borrow !== exp_borrow) begin
            failures++;
            $display("FAIL %s hold: done=%b busy=%b diff=%h borrow=%b, required 0 0 %h %b",
                     name, done, busy, diff, borrow, exp_diff, exp_borrow);
        end
        $display("op %s: a=%h b=%h diff=%h borrow=%b", name, ta, tb_, diff, borrow);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        step();
        step();
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow);
        end
        rst = 1'b0;
        step();
        $display("reset: busy=%b done=%b diff=%h borrow=%b", busy, done, diff, borrow);
    endtask

    task automatic test_directed();
        do_op(4'd9, 4'd3, "9-3");
        do_op(4'd3, 4'd9, "3-9");
        do_op(4'd0, 4'd1, "0-1");
        do_op(4'hF, 4'hF, "F-F");
        do_op(4'b0111, 4'b1000, "7-8");
        do_op(4'b1000, 4'b0001, "8-1");
        do_op(4'd5, 4'd3, "5-3");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), "rand");
        end
    endtask

    task automatic test_ignore_busy_start();
        int dones = 0;
        logic [W-1:0] seen_diff = '0;
        logic         seen_borrow = 1'b0;
        start = 1'b1; a = 4'd5; b = 4'd2;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1; a = 4'd1; b = 4'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            if (done) begin
                dones++;
                seen_diff = diff;
                seen_borrow = borrow;
            end
            step();
        end
        assertions++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d, required 1", dones);
        end
        assertions++;
        if (seen_diff !== 4'd3 || seen_borrow !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: diff=%h borrow=%b, required 3 0", seen_diff, seen_borrow);
        end
        $display("ignore: dones=%0d diff=%h borrow=%b", dones, seen_diff, seen_borrow);
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        start = 1'b1; a = 4'd9; b = 4'd3;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (done) dones++;
            step();
        end
        assertions++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses, required 0", dones);
        end
        $display("abort: dones=%0d", dones);
        do_op(4'd2, 4'd1, "2-1");
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int last = -1;
        int waits = 0;
        start = 1'b1; a = 4'd6; b = 4'd6;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                dones++;
                assertions++;
                if (diff !== '0 || borrow !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_result: diff=%h borrow=%b, required 0 0", diff, borrow);
                end
                if (last >= 0) begin
                    assertions++;
                    if (i - last !== W + 2) begin
                        failures++;
                        $display("FAIL b2b_interval: got %0d, required %0d", i - last, W + 2);
                    end
                end
                last = i;
            end
        end
        start = 1'b0;
        assertions++;
        if (dones !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d, required 3", dones);
        end
        while (busy && waits < BOUND) begin
            step();
            waits++;
        end
        assertions++;
        if (busy) begin
            failures++;
            $display("FAIL b2b_drain timeout: busy still high");
        end
        $display("back_to_back: dones=%0d", dones);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
